// File: rtl/alu_op_sequencer_if.sv
// Bundle of the operand and button inputs and the held ALU-facing outputs of alu_op_sequencer.
// The slave modport is the sequencer; the master modport is whoever drives switches and buttons.
interface alu_op_sequencer_if #(
  parameter int N = 4
);
  logic [N-1:0] sw_num;
  logic [3:0]   btn_n;
  logic [1:0]   mode_sw;
  logic [N-1:0] A_num;
  logic [N-1:0] B_num;
  logic [3:0]   operations_buttons;
  logic [1:0]   change_mode;
  logic [1:0]   seq_state;
  logic         result_valid;

  modport master (
    output sw_num, btn_n, mode_sw,
    input  A_num, B_num, operations_buttons, change_mode, seq_state, result_valid
  );

  modport slave (
    input  sw_num, btn_n, mode_sw,
    output A_num, B_num, operations_buttons, change_mode, seq_state, result_valid
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Debounces four active-low buttons and steps through load A / load B / select op,
// presenting registered, stable operands and operation code to the combinational ALU.
module alu_op_sequencer #(
  parameter int N               = 4,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input logic               clk,
  input logic               rst,
  alu_op_sequencer_if.slave bus
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    LOAD_A    = 2'b00,
    LOAD_B    = 2'b01,
    SELECT_OP = 2'b10,
    SHOW      = 2'b11
  } state_e;

  logic [3:0]    sync1_q, sync2_q;
  logic [3:0]    deb_q, deb_d, deb_dly_q;
  logic [3:0]    press_q;
  logic [CW-1:0] cnt_q [4];
  logic [CW-1:0] cnt_d [4];

  logic          evt_vld_s;
  logic [1:0]    evt_idx_s;
  logic          op_ok_s;

  state_e        state_q, state_d;
  logic [N-1:0]  a_q, a_d, b_q, b_d;
  logic [3:0]    ops_q, ops_d;
  logic [1:0]    mode_q, mode_d;
  logic          valid_q, valid_d;

  // Synchroniser, debounce state and registered falling-edge (press) pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= 4'hF;
      sync2_q   <= 4'hF;
      deb_q     <= 4'hF;
      deb_dly_q <= 4'hF;
      press_q   <= 4'h0;
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q   <= bus.btn_n;
      sync2_q   <= sync1_q;
      deb_q     <= deb_d;
      deb_dly_q <= deb_q;
      press_q   <= deb_dly_q & ~deb_q;
      for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // A level is accepted only after it differs from the debounced level for DEBOUNCE_CYCLES cycles.
  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          deb_d[i] = sync2_q[i];
          cnt_d[i] = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end else begin
        cnt_d[i] = '0;
      end
    end
  end

  // Lowest-index press wins; simultaneous higher-index presses are dropped.
  always_comb begin
    evt_vld_s = (press_q != 4'h0);
    if (press_q[0]) begin
      evt_idx_s = 2'd0;
    end else if (press_q[1]) begin
      evt_idx_s = 2'd1;
    end else if (press_q[2]) begin
      evt_idx_s = 2'd2;
    end else if (press_q[3]) begin
      evt_idx_s = 2'd3;
    end else begin
      evt_idx_s = 2'd0;
    end
  end

  assign op_ok_s = (bus.mode_sw != 2'b11);

  // State and held output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOAD_A;
      a_q     <= '0;
      b_q     <= '0;
      ops_q   <= 4'b1111;
      mode_q  <= 2'b00;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ops_q   <= ops_d;
      mode_q  <= mode_d;
      valid_q <= valid_d;
    end
  end

  // Next-state logic; the FSM only moves on an accepted press.
  always_comb begin
    state_d = state_q;
    if (evt_vld_s) begin
      case (state_q)
        LOAD_A:    state_d = LOAD_B;
        LOAD_B:    state_d = SELECT_OP;
        SELECT_OP: state_d = op_ok_s ? SHOW : SELECT_OP;
        SHOW:      state_d = op_ok_s ? SHOW : LOAD_A;
        default:   state_d = LOAD_A;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Output next values; A/B survive a restart until they are reloaded.
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    ops_d   = ops_q;
    mode_d  = mode_q;
    valid_d = (state_d == SHOW);
    if (evt_vld_s) begin
      case (state_q)
        LOAD_A: a_d = bus.sw_num;
        LOAD_B: b_d = bus.sw_num;
        SELECT_OP, SHOW: begin
          if (op_ok_s) begin
            ops_d  = ~(4'b0001 << evt_idx_s);
            mode_d = bus.mode_sw;
          end else if (state_q == SHOW) begin
            ops_d  = 4'b1111;
          end else begin
            ops_d  = ops_q;
          end
        end
        default: ops_d = 4'b1111;
      endcase
    end else begin
      ops_d = ops_q;
    end
  end

  assign bus.A_num              = a_q;
  assign bus.B_num              = b_q;
  assign bus.operations_buttons = ops_q;
  assign bus.change_mode        = mode_q;
  assign bus.seq_state          = state_q;
  assign bus.result_valid       = valid_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with DEBOUNCE_CYCLES=4, N=4; expected values are hand-computed.
module tb_alu_op_sequencer;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  alu_op_sequencer_if #(.N(4)) bus ();

  alu_op_sequencer #(.N(4), .DEBOUNCE_CYCLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] a, input logic [3:0] b,
                           input logic [3:0] ops, input logic [1:0] mode,
                           input logic [1:0] st, input logic vld);
    check_eq({tag, ".A"},     32'(bus.A_num), 32'(a));
    check_eq({tag, ".B"},     32'(bus.B_num), 32'(b));
    check_eq({tag, ".ops"},   32'(bus.operations_buttons), 32'(ops));
    check_eq({tag, ".mode"},  32'(bus.change_mode), 32'(mode));
    check_eq({tag, ".state"}, 32'(bus.seq_state), 32'(st));
    check_eq({tag, ".valid"}, 32'(bus.result_valid), 32'(vld));
  endtask

  // Hold the masked buttons low, release, then let the release debounce settle.
  task automatic press(input logic [3:0] mask, input int hold);
    bus.btn_n = ~mask;
    tick(hold);
    bus.btn_n = 4'hF;
    tick(8);
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    rst         = 1'b1;
    bus.btn_n   = 4'hF;
    bus.sw_num  = 4'h0;
    bus.mode_sw = 2'b00;

    // 1. reset
    tick(2);
    rst = 1'b0;
    check_all("reset", 4'h0, 4'h0, 4'b1111, 2'b00, 2'b00, 1'b0);

    // 2. full entry
    bus.sw_num = 4'h5;
    press(4'b0001, 10);
    check_all("loadA", 4'h5, 4'h0, 4'b1111, 2'b00, 2'b01, 1'b0);
    bus.sw_num = 4'h3;
    press(4'b0100, 10);
    check_all("loadB", 4'h5, 4'h3, 4'b1111, 2'b00, 2'b10, 1'b0);
    bus.mode_sw = 2'b00;
    press(4'b0010, 10);
    check_all("show", 4'h5, 4'h3, 4'b1101, 2'b00, 2'b11, 1'b1);
    bus.sw_num = 4'hE;
    tick(20);
    check_all("hold", 4'h5, 4'h3, 4'b1101, 2'b00, 2'b11, 1'b1);

    // restart from SHOW with invalid bank
    bus.mode_sw = 2'b11;
    press(4'b1000, 10);
    check_all("restart1", 4'h5, 4'h3, 4'b1111, 2'b00, 2'b00, 1'b0);

    // 3. bounce rejection
    bus.sw_num = 4'hA;
    for (int k = 0; k < 5; k++) begin
      bus.btn_n = 4'hE;
      tick(2);
      bus.btn_n = 4'hF;
      tick(2);
    end
    tick(10);
    check_all("bounce", 4'h5, 4'h3, 4'b1111, 2'b00, 2'b00, 1'b0);
    bus.btn_n = 4'hE;
    tick(3);
    bus.btn_n = 4'hF;
    tick(10);
    check_eq("glitch3.state", 32'(bus.seq_state), 32'd0);
    bus.btn_n = 4'hE;
    tick(7);
    check_eq("clean.t6.A", 32'(bus.A_num), 32'h5);
    bus.btn_n = 4'hF;
    tick(1);
    check_eq("clean.t7.A", 32'(bus.A_num), 32'hA);
    check_eq("clean.t7.state", 32'(bus.seq_state), 32'd1);
    tick(8);
    check_eq("clean.once", 32'(bus.seq_state), 32'd1);

    // 4. simultaneous press in SELECT_OP
    bus.sw_num = 4'h7;
    press(4'b0001, 10);
    check_eq("simul.pre.state", 32'(bus.seq_state), 32'd2);
    bus.mode_sw = 2'b01;
    press(4'b1010, 10);
    check_all("simul", 4'hA, 4'h7, 4'b1101, 2'b01, 2'b11, 1'b1);
    tick(10);
    check_eq("simul.drop", 32'(bus.operations_buttons), 32'hD);

    // 5. invalid bank in SELECT_OP, then restart from SHOW
    bus.mode_sw = 2'b11;
    press(4'b0001, 10);
    bus.sw_num = 4'h1;
    press(4'b0001, 10);
    bus.sw_num = 4'h2;
    press(4'b0001, 10);
    check_all("sel.pre", 4'h1, 4'h2, 4'b1111, 2'b01, 2'b10, 1'b0);
    press(4'b0001, 10);
    check_all("sel.inv", 4'h1, 4'h2, 4'b1111, 2'b01, 2'b10, 1'b0);
    bus.mode_sw = 2'b00;
    press(4'b0100, 10);
    check_all("sel.ok", 4'h1, 4'h2, 4'b1011, 2'b00, 2'b11, 1'b1);
    bus.mode_sw = 2'b11;
    press(4'b0001, 10);
    check_all("restart2", 4'h1, 4'h2, 4'b1111, 2'b00, 2'b00, 1'b0);

    // 6. reset mid-debounce, button kept low through reset release
    bus.sw_num = 4'hC;
    bus.btn_n  = 4'hE;
    tick(3);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check_all("midrst", 4'h0, 4'h0, 4'b1111, 2'b00, 2'b00, 1'b0);
    tick(7);
    check_eq("midrst.t7.state", 32'(bus.seq_state), 32'd0);
    tick(1);
    check_eq("midrst.t8.state", 32'(bus.seq_state), 32'd1);
    check_eq("midrst.t8.A", 32'(bus.A_num), 32'hC);
    bus.btn_n = 4'hF;
    tick(8);
    check_eq("midrst.once", 32'(bus.seq_state), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
